// File: rtl/fir_pkg.sv
// Shared types, width helpers and narrowing for the FIR MAC engine.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  function automatic int unsigned wclog2(
    input int unsigned n
  );
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned acc_w(
    input int unsigned dw,
    input int unsigned cw,
    input int unsigned taps
  );
    return dw + cw + $clog2(taps);
  endfunction

  // Clamp to ow-bit signed range when sat is set; otherwise pass through.
  function automatic logic signed [127:0] clamp(
    input logic signed [127:0] v,
    input int unsigned         ow,
    input logic                sat
  );
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (ow - 1)) - 128'sd1;
    lo = ~hi;
    if (sat && v > hi) return hi;
    if (sat && v < lo) return lo;
    return v;
  endfunction

  function automatic logic clipped(
    input logic signed [127:0] v,
    input int unsigned         ow
  );
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (ow - 1)) - 128'sd1;
    lo = ~hi;
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate with shift and narrowing output register.
// FIR_SATURATE_EN selects clamping plus clip flag instead of wrap.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 35,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              load,
  input  logic [DATA_W-1:0] a,
  input  logic [COEF_W-1:0] b,
  output logic [OUT_W-1:0]  result,
  output logic              clip
);

  localparam int PW = DATA_W + COEF_W;

`ifdef FIR_SATURATE_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [127:0]     wide;

  assign prod = PW'($signed(a)) * PW'($signed(b));
  assign wide = 128'(acc >>> SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else if (load) begin
      result <= OUT_W'(clamp(wide, OUT_W, SAT));
    end
  end

`ifdef FIR_SATURATE_EN
  logic clip_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_r <= 1'b0;
    end else if (load) begin
      clip_r <= clipped(wide, OUT_W);
    end
  end

  assign clip = clip_r;
`else
  assign clip = 1'b0;
`endif

endmodule

// File: rtl/fir_mac_engine.sv
// Multi-channel time-multiplexed FIR engine: delay lines, coef RAM, FSM.
// FIR_SATURATE_EN enables output clamping and sat_flag.
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter  int DATA_W   = 16,
  parameter  int COEF_W   = 16,
  parameter  int TAPS     = 5,
  parameter  int CHANNELS = 2,
  parameter  int OUT_W    = 16,
  parameter  int SHIFT    = 0,
  localparam int CH_W     = wclog2(CHANNELS),
  localparam int AW       = wclog2(TAPS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  input  logic              clear_hist,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [CH_W-1:0]   out_chan,
  output logic              busy,
  output logic              sat_flag
);

  localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);
  localparam int TW    = wclog2(TAPS + 1);

  state_t            state;
  state_t            nxt;
  logic [TW-1:0]     tap;
  logic [CH_W-1:0]   ch;
  logic [AW-1:0]     ti;
  logic [DATA_W-1:0] hist [CHANNELS][TAPS];
  logic [COEF_W-1:0] coef [TAPS];
  logic              idle;
  logic              legal;
  logic              accept;
  logic              last;
  logic              mac_en;
  logic              mac_ld;

  assign idle   = (state == IDLE);
  assign legal  = 32'(in_chan) < CHANNELS;
  assign accept = idle && in_valid && legal;
  assign last   = (tap == TW'(TAPS));
  assign mac_en = (state == MAC) && !last;
  assign mac_ld = (state == MAC) && last;
  assign ti     = last ? '0 : tap[AW-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept)    nxt = MAC;
      MAC:     if (last)      nxt = OUT;
      OUT:     if (out_ready) nxt = IDLE;
      default:                nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tap <= '0;
      ch  <= '0;
    end else if (accept) begin
      tap <= '0;
      ch  <= in_chan;
    end else if (state == MAC) begin
      tap <= tap + 1'b1;
    end
  end

  // Clear is ordered before the shift-in so the sample lands in a zeroed line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int t = 0; t < TAPS; t++)
          hist[c][t] <= '0;
    end else if (idle) begin
      if (clear_hist)
        for (int c = 0; c < CHANNELS; c++)
          for (int t = 0; t < TAPS; t++)
            hist[c][t] <= '0;
      if (accept) begin
        for (int t = TAPS - 1; t > 0; t--)
          hist[in_chan][t] <= clear_hist ? '0 : hist[in_chan][t-1];
        hist[in_chan][0] <= in_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int t = 0; t < TAPS; t++)
        coef[t] <= '0;
    end else if (idle && coef_we && 32'(coef_addr) < TAPS) begin
      coef[coef_addr] <= coef_wdata;
    end
  end

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) u_mac (
    .clk    (clock),
    .rst_n  (reset),
    .clr    (accept),
    .en     (mac_en),
    .load   (mac_ld),
    .a      (hist[ch][ti]),
    .b      (coef[ti]),
    .result (out_data),
    .clip   (sat_flag)
  );

  assign in_ready  = idle;
  assign busy      = !idle;
  assign out_valid = (state == OUT);
  assign out_chan  = ch;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Randomised plus directed bench for fir_mac_engine against a sum-of-products model.
// FIR_SATURATE_EN selects the clamping expectations.
module tb_fir_mac_engine;

  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int TAPS = 5;
  localparam int CH   = 3;
  localparam int OW   = 16;
  localparam int SH   = 0;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          coef_we = 1'b0;
  logic [2:0]    coef_addr = '0;
  logic [CW-1:0] coef_wdata = '0;
  logic          clear_hist = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [1:0]    in_chan = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic [1:0]    out_chan;
  logic          busy;
  logic          sat_flag;

  always #5 clock = ~clock;

  fir_mac_engine #(
    .DATA_W   (DW),
    .COEF_W   (CW),
    .TAPS     (TAPS),
    .CHANNELS (CH),
    .OUT_W    (OW),
    .SHIFT    (SH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .clear_hist (clear_hist),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_chan    (in_chan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .busy       (busy),
    .sat_flag   (sat_flag)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: per-channel history arrays and coefficient table.
  longint        mh [CH][TAPS];
  longint        mc [TAPS];
  bit            pending = 1'b0;
  longint        cyc = 0;
  longint        acc_cyc = 0;
  logic [OW-1:0] e_d;
  int            e_c;
  bit            e_s;
  longint        got [$];

  function automatic void model_eval(int c);
    longint s;
    longint lim;
    s = 0;
    for (int t = 0; t < TAPS; t++) s += mh[c][t] * mc[t];
    s = s >>> SH;
    lim = longint'(1) << (OW - 1);
    e_s = 1'b0;
`ifdef FIR_SATURATE_EN
    if (s > lim - 1) begin s = lim - 1; e_s = 1'b1; end
    if (s < -lim)    begin s = -lim;    e_s = 1'b1; end
`endif
    e_d = s[OW-1:0];
    e_c = c;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    bit eov;
    if (!reset) begin
      pending = 1'b0;
      for (int c = 0; c < CH; c++)
        for (int t = 0; t < TAPS; t++) mh[c][t] = 0;
      for (int t = 0; t < TAPS; t++) mc[t] = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_chan", out_chan, 0);
      chk("rst_sat", sat_flag, 0);
    end else begin
      eov = pending && (cyc - acc_cyc >= TAPS + 1);
      chk("out_valid", out_valid, eov);
      chk("in_ready", in_ready, !pending);
      chk("busy", busy, pending);
      if (eov) begin
        chk("out_data", out_data, e_d);
        chk("out_chan", out_chan, e_c);
        chk("sat_flag", sat_flag, e_s);
      end
      if (eov && out_valid && out_ready) begin
        pending = 1'b0;
        got.push_back(longint'($signed(out_data)));
      end else if (!pending) begin
        if (coef_we && coef_addr < TAPS)
          mc[coef_addr] = longint'($signed(coef_wdata));
        if (clear_hist)
          for (int c = 0; c < CH; c++)
            for (int t = 0; t < TAPS; t++) mh[c][t] = 0;
        if (in_valid && int'(in_chan) < CH) begin
          for (int t = TAPS - 1; t > 0; t--)
            mh[in_chan][t] = mh[in_chan][t-1];
          mh[in_chan][0] = longint'($signed(in_data));
          model_eval(int'(in_chan));
          pending = 1'b1;
          acc_cyc = cyc + 1;
        end
      end
    end
  end

  task automatic timeout(string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out", nm);
  endtask

  task automatic send(int c, int d, bit clr = 1'b0);
    bit ok;
    @(posedge clock); #1;
    in_valid   = 1'b1;
    in_chan    = 2'(c);
    in_data    = 16'(d);
    clear_hist = clr;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clock); #1;
    in_valid   = 1'b0;
    clear_hist = 1'b0;
    if (!ok) timeout("send");
  endtask

  task automatic wcoef(int a, int v);
    @(posedge clock); #1;
    coef_we    = 1'b1;
    coef_addr  = 3'(a);
    coef_wdata = 16'(v);
    @(posedge clock); #1;
    coef_we = 1'b0;
  endtask

  task automatic clr_hist();
    @(posedge clock); #1;
    clear_hist = 1'b1;
    @(posedge clock); #1;
    clear_hist = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock); #1;
      if (!pending) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("drain");
  endtask

  task automatic lit(string nm, int idx, longint v);
    if (idx < got.size()) chk(nm, got[idx], v);
    else chk({nm, "_missing"}, got.size(), idx + 1);
  endtask

  initial begin
    bit ok;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Single channel, coefficients 1..5
    for (int t = 0; t < TAPS; t++) wcoef(t, t + 1);
    clr_hist();
    got.delete();
    for (int i = 1; i <= 5; i++) begin send(0, i); wait_done(); end
    lit("t1_y0", 0, 1);
    lit("t1_y1", 1, 4);
    lit("t1_y2", 2, 10);
    lit("t1_y3", 3, 20);
    lit("t1_y4", 4, 35);

    // Interleaved channels
    clr_hist();
    got.delete();
    for (int i = 1; i <= 3; i++) begin
      send(0, i);      wait_done();
      send(1, 10 * i); wait_done();
    end
    lit("t2_a0", 0, 1);
    lit("t2_b0", 1, 10);
    lit("t2_a1", 2, 4);
    lit("t2_b1", 3, 40);
    lit("t2_a2", 4, 10);
    lit("t2_b2", 5, 100);

    // Backpressure with an ignored coefficient write
    clr_hist();
    got.delete();
    out_ready = 1'b0;
    send(0, 2);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("stall_valid");
    repeat (3) @(posedge clock);
    wcoef(0, 100);
    repeat (5) @(posedge clock);
    #1 out_ready = 1'b1;
    wait_done();
    send(0, 1);
    wait_done();
    lit("t3_stall", 0, 2);
    lit("t3_oldcoef", 1, 5);

    // Overflow
    wcoef(0, 32767);
    for (int t = 1; t < TAPS; t++) wcoef(t, 0);
    clr_hist();
    got.delete();
    send(0, 32767);
    wait_done();
`ifdef FIR_SATURATE_EN
    lit("t4_ovf", 0, 32767);
    chk("t4_sat", sat_flag, 1);
`else
    lit("t4_ovf", 0, 1);
    chk("t4_sat", sat_flag, 0);
`endif

    // Reset two cycles into MAC
    for (int t = 0; t < TAPS; t++) wcoef(t, t + 1);
    send(0, 4);
    @(posedge clock); #2;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (12) @(posedge clock);
    got.delete();
    send(0, 7);
    wait_done();
    lit("t5_after_rst", 0, 0);

    // Clear together with a sample
    for (int t = 0; t < TAPS; t++) wcoef(t, t + 1);
    got.delete();
    send(0, 5);
    wait_done();
    send(0, 9, 1'b1);
    wait_done();
    lit("t6_clear_in", 1, 9);

    // Illegal channel leaves every line untouched
    send(3, 50);
    repeat (10) @(posedge clock);
    send(0, 1);
    wait_done();
    send(1, 2);
    wait_done();
    lit("t7_ch0", 2, 19);
    lit("t7_ch1", 3, 2);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      in_valid   = ($urandom % 3) == 0;
      in_chan    = 2'($urandom % 4);
      in_data    = 16'($urandom);
      clear_hist = ($urandom % 20) == 0;
      coef_we    = !in_valid && (($urandom % 6) == 0);
      coef_addr  = 3'($urandom % 8);
      coef_wdata = 16'($urandom);
      out_ready  = ($urandom % 4) != 0;
    end
    @(posedge clock); #1;
    in_valid   = 1'b0;
    clear_hist = 1'b0;
    coef_we    = 1'b0;
    out_ready  = 1'b1;
    wait_done();

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
